screen_refresh_scheduler: RTL and testbench

- Fills the 12-row tile screen buffer that feeds the color mapper from the world tile map RAM, once per frame during vertical blank.
- The window is 16×12 tiles at 40 px per tile, with the top-left tile at (corner_x, corner_y).
- Shares the single-port world map RAM between refresh reads and game-logic block edits (place/break), so the pixel path never sees a half-updated window.

---
 rtl/screen_refresh_scheduler_if.sv | 37 +++
 rtl/screen_refresh_scheduler.sv | 179 +++++++++++++++++
 tb/tb_screen_refresh_scheduler.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/screen_refresh_scheduler_if.sv
// Signal bundle between the refresh scheduler and its environment: frame and
// corner control, the edit handshake, the world-map RAM port and the screen-buffer row port.
interface screen_refresh_scheduler_if #(
  parameter int COLS     = 16,
  parameter int TILE_W   = 4,
  parameter int MAP_LOG2 = 7
);
  logic                     frame_start;
  logic [MAP_LOG2-1:0]      corner_x;
  logic [MAP_LOG2-1:0]      corner_y;
  logic                     edit_req;
  logic [MAP_LOG2-1:0]      edit_x;
  logic [MAP_LOG2-1:0]      edit_y;
  logic [TILE_W-1:0]        edit_id;
  logic                     edit_ack;
  logic [2*MAP_LOG2-1:0]    map_addr;
  logic                     map_we;
  logic [TILE_W-1:0]        map_wdata;
  logic [TILE_W-1:0]        map_rdata;
  logic                     row_wr_en;
  logic [3:0]               row_wr_idx;
  logic [COLS*TILE_W-1:0]   row_wr_data;
  logic                     busy;
  logic                     frame_done;

  modport master (
    input  frame_start, corner_x, corner_y, edit_req, edit_x, edit_y, edit_id, map_rdata,
    output edit_ack, map_addr, map_we, map_wdata, row_wr_en, row_wr_idx, row_wr_data,
           busy, frame_done
  );

  modport slave (
    output frame_start, corner_x, corner_y, edit_req, edit_x, edit_y, edit_id, map_rdata,
    input  edit_ack, map_addr, map_we, map_wdata, row_wr_en, row_wr_idx, row_wr_data,
           busy, frame_done
  );
endinterface

// File: rtl/screen_refresh_scheduler.sv
// Copies the visible tile window from the world map RAM into the screen buffer once
// per frame, slotting game-logic tile edits in at row boundaries.
module screen_refresh_scheduler #(
  parameter int ROWS     = 12,
  parameter int COLS     = 16,
  parameter int TILE_W   = 4,
  parameter int MAP_LOG2 = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  screen_refresh_scheduler_if.master bus
);
  localparam int COL_W   = $clog2(COLS);
  localparam int SHIFT_W = (COLS - 1) * TILE_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [3:0]       LAST_ROW = 4'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EDIT   = 3'd1,
    LATCH  = 3'd2,
    READ   = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                pending_r;
  logic                edit_ret_r;
  logic [MAP_LOG2-1:0] cx_r;
  logic [MAP_LOG2-1:0] cy_r;
  logic [MAP_LOG2-1:0] map_x_s;
  logic [MAP_LOG2-1:0] map_y_s;
  logic [3:0]          row_r;
  logic [COL_W-1:0]    col_r;
  logic [SHIFT_W-1:0]  shift_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pending flag, latched window corner, row/column counters and row assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r  <= 1'b0;
      edit_ret_r <= 1'b0;
      cx_r       <= '0;
      cy_r       <= '0;
      row_r      <= 4'd0;
      col_r      <= '0;
      shift_r    <= '0;
    end else begin
      // A pulse arriving during LATCH belongs to the next frame, so it survives the clear.
      pending_r <= bus.frame_start | (pending_r & (state_r != LATCH));
      if (state_r != EDIT) begin
        edit_ret_r <= (state_r == COMMIT);
      end
      case (state_r)
        LATCH: begin
          cx_r  <= bus.corner_x;
          cy_r  <= bus.corner_y;
          row_r <= 4'd0;
          col_r <= '0;
        end
        READ: begin
          col_r <= col_r + COL_W'(1);
          // Read data lags the address by one cycle, so column 0 has nothing to capture yet.
          if (col_r != '0) begin
            shift_r <= {bus.map_rdata, shift_r[SHIFT_W-1:TILE_W]};
          end
        end
        COMMIT: begin
          col_r <= '0;
          if (row_r != LAST_ROW) begin
            row_r <= row_r + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.edit_req) begin
          state_s = EDIT;
        end else if (bus.frame_start || pending_r) begin
          state_s = LATCH;
        end else begin
          state_s = IDLE;
        end
      end
      EDIT: begin
        if (edit_ret_r) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      LATCH: state_s = READ;
      READ: begin
        if (col_r == LAST_COL) begin
          state_s = COMMIT;
        end else begin
          state_s = READ;
        end
      end
      COMMIT: begin
        if (row_r == LAST_ROW) begin
          state_s = DONE;
        end else if (bus.edit_req) begin
          state_s = EDIT;
        end else begin
          state_s = READ;
        end
      end
      DONE: begin
        // A queued frame restarts at once unless an edit is waiting for its IDLE slot.
        if (pending_r && !bus.edit_req) begin
          state_s = LATCH;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.edit_ack    = 1'b0;
    bus.map_we      = 1'b0;
    bus.map_addr    = '0;
    bus.map_wdata   = '0;
    bus.row_wr_en   = 1'b0;
    bus.row_wr_idx  = 4'd0;
    bus.row_wr_data = '0;
    bus.busy        = 1'b0;
    bus.frame_done  = 1'b0;
    map_x_s         = cx_r + MAP_LOG2'(col_r);
    map_y_s         = cy_r + MAP_LOG2'(row_r);
    case (state_r)
      EDIT: begin
        bus.map_we    = 1'b1;
        bus.map_addr  = {bus.edit_y, bus.edit_x};
        bus.map_wdata = bus.edit_id;
        bus.edit_ack  = 1'b1;
        bus.busy      = edit_ret_r;
      end
      LATCH: bus.busy = 1'b1;
      READ: begin
        bus.busy     = 1'b1;
        bus.map_addr = {map_y_s, map_x_s};
      end
      COMMIT: begin
        bus.busy        = 1'b1;
        bus.row_wr_en   = 1'b1;
        bus.row_wr_idx  = row_r;
        bus.row_wr_data = {bus.map_rdata, shift_r};
      end
      DONE: begin
        bus.busy       = 1'b1;
        bus.frame_done = 1'b1;
      end
      default: begin
      end
    endcase
  end
endmodule

// File: tb/tb_screen_refresh_scheduler.sv
// Self-checking bench: world RAM model, window reference computed with modular
// arithmetic, and directed plus randomized frame/edit scenarios.
module tb_screen_refresh_scheduler;
  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  screen_refresh_scheduler_if bus ();
  screen_refresh_scheduler dut (.clk(clk), .reset(reset), .bus(bus.master));

  logic [3:0]  mem [0:16383];
  int          fill_mode;
  int          fcx, fcy;
  int          exp_row, rows_total, latch_cyc, ack_cyc, we_cycles, edits_issued;
  logic        prev_edit, ack_busy;
  logic [13:0] ack_addr;
  int          row_cyc [0:11];
  logic [63:0] last_rows [0:11];
  int          done_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // World RAM: bulk fill on request, edit writes, one-cycle read latency
  always @(posedge clk) begin
    if (fill_mode == 1) begin
      for (int a = 0; a < 16384; a++) mem[a] <= 4'(((a % 128) + (a / 128)) % 16);
    end else if (fill_mode == 2) begin
      for (int a = 0; a < 16384; a++) mem[a] <= 4'($urandom);
    end else if (bus.map_we) begin
      mem[bus.map_addr] <= bus.map_wdata;
    end
    bus.map_rdata <= mem[bus.map_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] window_row(input int r);
    logic [63:0] w;
    w = 64'd0;
    for (int c = 0; c < 16; c++)
      w[4*c +: 4] = mem[((fcy + r) % 128) * 128 + ((fcx + c) % 128)];
    return w;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(input int m);
    fill_mode = m;
    step(1);
    fill_mode = 0;
  endtask

  task automatic start_frame(input int cx, input int cy);
    bus.corner_x    = 7'(cx);
    bus.corner_y    = 7'(cy);
    fcx             = cx;
    fcy             = cy;
    bus.frame_start = 1'b1;
    latch_cyc       = cyc + 1;
    step(1);
    bus.frame_start = 1'b0;
  endtask

  task automatic pulse_frame();
    bus.frame_start = 1'b1;
    step(1);
    bus.frame_start = 1'b0;
  endtask

  task automatic do_edit(input int x, input int y, input int id);
    int k;
    k = 0;
    bus.edit_x   = 7'(x);
    bus.edit_y   = 7'(y);
    bus.edit_id  = 4'(id);
    bus.edit_req = 1'b1;
    edits_issued++;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.edit_ack && k < 60);
    check_eq("edit_ack_seen", bus.edit_ack, 1'b1);
    bus.edit_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n0, input int cnt, input int limit);
    int k;
    k = 0;
    while (done_q.size() < n0 + cnt && k < limit) begin
      step(1);
      k++;
    end
    check_eq("frame_done_seen", done_q.size() >= n0 + cnt, 1'b1);
  endtask

  // Output monitor and scoreboard, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_row   = 0;
      prev_edit = 1'b0;
    end else begin
      if (bus.map_we) we_cycles++;
      if (bus.edit_ack) begin
        ack_cyc  = cyc;
        ack_busy = bus.busy;
        ack_addr = bus.map_addr;
        check_eq("ack_we", bus.map_we, 1'b1);
        check_eq("ack_addr", bus.map_addr, {bus.edit_y, bus.edit_x});
        check_eq("ack_wdata", bus.map_wdata, bus.edit_id);
      end
      if (bus.row_wr_en) begin
        check_eq("row_in_frame", exp_row < 12, 1'b1);
        if (exp_row < 12) begin
          check_eq("row_idx", bus.row_wr_idx, exp_row);
          check_eq("row_data", bus.row_wr_data, window_row(exp_row));
          if (exp_row > 0)
            check_eq("row_pitch", cyc - row_cyc[exp_row-1], prev_edit ? 18 : 17);
          row_cyc[exp_row]   = cyc;
          last_rows[exp_row] = bus.row_wr_data;
        end
        prev_edit = bus.edit_req && (exp_row < 11);
        rows_total++;
        exp_row++;
      end
      if (bus.frame_done) begin
        check_eq("done_rows", exp_row, 12);
        done_q.push_back(cyc);
        exp_row = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, rb, db, cx, cy;
    logic [63:0] w;
    logic [3:0]  nib;
    checks = 0; errors = 0; cyc = 0; fill_mode = 0;
    exp_row = 0; rows_total = 0; we_cycles = 0; edits_issued = 0; prev_edit = 1'b0;
    reset = 1'b1;
    bus.frame_start = 1'b1; bus.edit_req = 1'b1;
    bus.edit_x = 7'd3; bus.edit_y = 7'd4; bus.edit_id = 4'd9;
    bus.corner_x = 7'd0; bus.corner_y = 7'd0;

    // Reset held three cycles with requests active
    step(1);
    check_eq("rst_ack_c1", bus.edit_ack, 1'b0);
    step(2);
    check_eq("rst_outs_c3", {bus.edit_ack, bus.row_wr_en, bus.busy, bus.map_we}, 4'd0);
    reset = 1'b0; bus.frame_start = 1'b0; bus.edit_req = 1'b0;
    step(1);
    check_eq("post_rst_flags",
             {bus.busy, bus.edit_ack, bus.map_we, bus.row_wr_en, bus.frame_done}, 5'd0);
    check_eq("post_rst_addr", bus.map_addr, 14'd0);
    check_eq("post_rst_data", bus.row_wr_data, 64'd0);
    check_eq("post_rst_wdata", bus.map_wdata, 4'd0);

    // Basic refresh, diagonal pattern, corner (0,0)
    fill(1);
    n0 = done_q.size(); rb = rows_total;
    start_frame(0, 0);
    check_eq("latch_busy", bus.busy, 1'b1);
    wait_frames(n0, 1, 400);
    check_eq("basic_rows", rows_total - rb, 12);
    check_eq("basic_row0_cyc", row_cyc[0], latch_cyc + 17);
    check_eq("basic_row11_cyc", row_cyc[11], latch_cyc + 17 * 12);
    check_eq("basic_done_cyc", done_q[n0], latch_cyc + 205);
    check_eq("basic_row0_data", last_rows[0], 64'hFEDCBA9876543210);
    step(2);
    check_eq("idle_busy", bus.busy, 1'b0);

    // Wrap-around window
    fill(2);
    n0 = done_q.size();
    start_frame(120, 126);
    step(9);
    check_eq("wrap_addr_r0c8", bus.map_addr, {7'd126, 7'd0});
    step(26);
    check_eq("wrap_addr_r2c0", bus.map_addr, {7'd0, 7'd120});
    wait_frames(n0, 1, 400);

    // Edit raised mid-row 3
    fill(1);
    n0 = done_q.size();
    start_frame(0, 0);
    step(60);
    do_edit(5, 5, 7);
    check_eq("edit_ack_cyc", ack_cyc, latch_cyc + 69);
    check_eq("edit_ack_busy", ack_busy, 1'b1);
    check_eq("edit_ack_addr", ack_addr, 14'h0285);
    wait_frames(n0, 1, 400);
    check_eq("edit_row4_cyc", row_cyc[4], latch_cyc + 86);
    check_eq("edit_done_cyc", done_q[n0], latch_cyc + 206);
    n0 = done_q.size();
    start_frame(0, 0);
    wait_frames(n0, 1, 400);
    w = last_rows[5];
    nib = w[23:20];
    check_eq("edit_next_frame", nib, 4'd7);

    // Pending frames collapse to one extra refresh
    fill(2);
    cx = int'($urandom_range(0, 127)); cy = int'($urandom_range(0, 127));
    n0 = done_q.size();
    start_frame(cx, cy);
    step(49);
    pulse_frame();
    step(49);
    pulse_frame();
    wait_frames(n0, 2, 900);
    check_eq("pend_done1", done_q[n0], latch_cyc + 205);
    check_eq("pend_done2", done_q[n0+1], latch_cyc + 411);
    check_eq("pend_row0_cyc", row_cyc[0], latch_cyc + 206 + 17);
    step(300);
    check_eq("pend_no_third", done_q.size(), n0 + 2);

    // Reset during row 6 with a frame already queued
    cx = int'($urandom_range(0, 127)); cy = int'($urandom_range(0, 127));
    start_frame(cx, cy);
    step(107);
    pulse_frame();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    rb = rows_total; db = done_q.size();
    step(300);
    check_eq("rst_no_rows", rows_total, rb);
    check_eq("rst_no_done", done_q.size(), db);
    check_eq("rst_idle_busy", bus.busy, 1'b0);
    start_frame(cy, cx);
    wait_frames(db, 1, 400);
    check_eq("rst_restart_row0", row_cyc[0], latch_cyc + 17);
    check_eq("rst_restart_rows", rows_total, rb + 12);

    // Randomized frames with one edit each and corner changes after LATCH
    for (int f = 0; f < 4; f++) begin
      int dly, ex, ey, eid;
      n0  = done_q.size();
      dly = int'($urandom_range(5, 190));
      ex  = int'($urandom_range(0, 127));
      ey  = int'($urandom_range(0, 127));
      eid = int'($urandom_range(0, 15));
      fork
        begin
          start_frame(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
          step(3);
          bus.corner_x = 7'($urandom);
          bus.corner_y = 7'($urandom);
        end
        begin
          step(dly);
          do_edit(ex, ey, eid);
        end
      join
      wait_frames(n0, 1, 600);
    end
    step(5);
    check_eq("we_count", we_cycles, edits_issued);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
